// File: rtl/cpu_oam_dma_arbiter_pkg.sv
// cpu_oam_dma_arbiter_pkg: shared CPU bus types and addresses for the OAM DMA arbiter
package cpu_oam_dma_arbiter_pkg;
    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;
    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam int          XFER_LEN      = 256;
    localparam logic [7:0]  LAST_INDEX    = 8'(XFER_LEN - 1);
endpackage

// File: rtl/cpu_bus_mux.sv
// cpu_bus_mux: selects whether the CPU or the DMA engine drives the memory bus
module cpu_bus_mux (
    input  logic        sel_dma,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_r_en,
    input  logic [7:0]  cpu_w_data,
    input  logic [15:0] dma_addr,
    input  logic        dma_r_en,
    input  logic [7:0]  dma_w_data,
    output logic [15:0] mem_addr,
    output logic        mem_r_en,
    output logic [7:0]  mem_w_data
);
    assign mem_addr   = sel_dma ? dma_addr   : cpu_addr;
    assign mem_r_en   = sel_dma ? dma_r_en   : cpu_r_en;
    assign mem_w_data = sel_dma ? dma_w_data : cpu_w_data;
endmodule

// File: rtl/cpu_register.sv
// cpu_register: generic load-enabled register with asynchronous active-low clear
module cpu_register #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // hold value until load, clear on reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else if (load) q <= d;
    end
endmodule

// File: rtl/cpu_oam_dma_arbiter.sv
// cpu_oam_dma_arbiter: CPU bus owner that runs 256-byte sprite DMA on a $4014 write.
// Define CPU_OAM_DMA_ALIGN_EN to insert the get/put parity alignment cycle (513/514 cycles);
// without it HALT always goes straight to READ (fixed 513 cycles).
module cpu_oam_dma_arbiter
    import cpu_oam_dma_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clock_en,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_r_en,
    input  logic [7:0]  cpu_w_data,
    input  logic [7:0]  mem_r_data,
    output logic [15:0] mem_addr,
    output logic        mem_r_en,
    output logic [7:0]  mem_w_data,
    output logic        cpu_stall,
    output logic        dma_active,
    output logic        dma_done
);
    dma_state_t  state, next_state;
    logic [7:0]  page, index;
    logic        parity, start, busy, dma_r_en;
    logic [15:0] dma_addr;
    logic [7:0]  dma_w_data;

    // only an idle bus accepts a new DMA request; later $4014 writes are ignored
    assign start = (state == DMA_IDLE) && (cpu_addr == DMA_REG_ADDR) && !cpu_r_en;

    cpu_register #(.WIDTH(8)) u_page (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (clock_en && start),
        .d       (cpu_w_data),
        .q       (page)
    );

    // state register advances only on CPU cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= DMA_IDLE;
        else if (clock_en) state <= next_state;
    end

    // byte index and get/put parity
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            index  <= '0;
            parity <= 1'b0;
        end else if (clock_en) begin
            parity <= ~parity;
            index  <= start ? 8'h00 : (state == DMA_WRITE) ? index + 8'h01 : index;
        end
    end

`ifdef CPU_OAM_DMA_ALIGN_EN
    // next state; HALT waits one extra cycle so READ lands on a get cycle
    always_comb begin
        next_state = state;
        unique case (state)
            DMA_IDLE:  next_state = start ? DMA_HALT : DMA_IDLE;
            DMA_HALT:  next_state = parity ? DMA_READ : DMA_ALIGN;
            DMA_ALIGN: next_state = DMA_READ;
            DMA_READ:  next_state = DMA_WRITE;
            DMA_WRITE: next_state = (index == LAST_INDEX) ? DMA_IDLE : DMA_READ;
            default:   next_state = DMA_IDLE;
        endcase
    end
`else
    logic unused_parity;
    assign unused_parity = parity;

    // next state; HALT always goes straight to READ
    always_comb begin
        next_state = state;
        unique case (state)
            DMA_IDLE:  next_state = start ? DMA_HALT : DMA_IDLE;
            DMA_HALT:  next_state = DMA_READ;
            DMA_ALIGN: next_state = DMA_READ;
            DMA_READ:  next_state = DMA_WRITE;
            DMA_WRITE: next_state = (index == LAST_INDEX) ? DMA_IDLE : DMA_READ;
            default:   next_state = DMA_IDLE;
        endcase
    end
`endif

    // DMA bus triple and status, decoded from state; HALT/ALIGN do a dummy page read
    always_comb begin
        busy       = state != DMA_IDLE;
        dma_r_en   = state != DMA_WRITE;
        dma_addr   = (state == DMA_WRITE) ? OAM_DATA_ADDR :
                     (state == DMA_READ)  ? {page, index} : {page, 8'h00};
        dma_w_data = mem_r_data;
        dma_done   = (state == DMA_WRITE) && (index == LAST_INDEX);
    end

    assign cpu_stall  = busy;
    assign dma_active = busy;

    cpu_bus_mux u_mux (
        .sel_dma    (busy),
        .cpu_addr   (cpu_addr),
        .cpu_r_en   (cpu_r_en),
        .cpu_w_data (cpu_w_data),
        .dma_addr   (dma_addr),
        .dma_r_en   (dma_r_en),
        .dma_w_data (dma_w_data),
        .mem_addr   (mem_addr),
        .mem_r_en   (mem_r_en),
        .mem_w_data (mem_w_data)
    );
endmodule
